id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register. It sits directly downstream of the instruction-decode controller.
- Registers every control field the decoder produces, plus operands, immediate, PC+4 and register indices, for the EX stage.
- Performs load-use hazard detection: on a hazard it stalls PC/IF-ID and inserts a bubble.
- Performs branch/jump flush, and holds state when the debug unit disables the pipeline.

Parameters:
- NB_DATA, 32, width of operand/immediate/PC fields
- NB_REG, 5, register index width
- NB_CNT, 32, perf counter width (used only with ID_EX_PERF_EN)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance enable from debug unit; 0 = freeze
- i_flush  in  1  squash the instruction currently in ID (taken branch/jump)
- i_reg_write, i_alu_source, i_mem_write, i_mem_read, i_beq_flag, i_bne_flag, i_jump_flag  in  1 each  decoder control bits
- i_alu_op  in  3  decoder ALU op
- i_data_to_reg, i_reg_dst, i_select_addr  in  2 each  decoder selects
- i_size_control  in  5  decoder load/store size code
- i_rs_data, i_rt_data, i_imm, i_pc4  in  NB_DATA each  operands, sign-extended immediate, PC+4
- i_rs, i_rt, i_rd  in  NB_REG each  register indices of the ID instruction
- o_<each control field>  out  same width  registered copies (o_reg_write … o_size_control)
- o_rs_data, o_rt_data, o_imm, o_pc4  out  NB_DATA  registered
- o_rs, o_rt, o_rd  out  NB_REG  registered
- o_valid  out  1  1 = EX holds a real instruction, 0 = bubble
- o_stall  out  1  combinational; freeze PC and IF/ID this cycle
- o_stall_count, o_flush_count  out  NB_CNT  perf counters

Behaviour:
- Reset: all registered outputs are 0, including o_valid=0. Counters are 0.
- Latency: one cycle from ID inputs to EX outputs.
- Operand-use decode (combinational, from ID inputs):
  - uses_rs = !(i_jump_flag && i_select_addr==2'b00). This excludes J and JAL.
  - uses_rt = !i_alu_source || i_mem_write.
- Hazard: o_mem_read && o_valid && o_rt!=0 && ((uses_rs && o_rt==i_rs) || (uses_rt && o_rt==i_rt)).
- o_stall = hazard && i_enable && !i_flush.
- Per-edge priority, first match wins:
  1. i_reset: clear everything.
  2. !i_enable: hold all registers, counters included.
  3. i_flush: load bubble.
  4. hazard: load bubble.
  5. Otherwise load all inputs and set o_valid=1.
- Bubble = every control output 0, data/index outputs 0, o_valid=0. A bubble must never write a register or memory, or branch.
- Stall duration:
  - Exactly one cycle per load-use pair. After the bubble, o_mem_read=0, so the hazard self-clears.
  - Back-to-back loads each stall independently.
- Simultaneous flush and hazard: flush wins and o_stall=0. The ID instruction is discarded, so there is nothing to preserve.
- i_enable=0 during a pending hazard: o_stall=0 and state is held. The stall reappears when i_enable returns to 1.
- Reset mid-stall: the next cycle has o_valid=0 and o_stall=0.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined:
  - o_stall_count increments on each enabled edge where a hazard bubble is loaded.
  - o_flush_count increments on each enabled edge where a flush bubble is loaded.
  - Both saturate at all-ones and clear on reset.
- Undefined: counter logic is absent and both outputs are tied to 0. Ports always exist.

Test Plan:
- Reset: assert i_reset 2 cycles with random inputs → all outputs 0, o_valid=0, o_stall=0.
- Pass-through: ADDI-style inputs (i_reg_write=1, i_alu_source=1, i_alu_op=3'b001, i_imm=32'h0000_0010, i_rs=3), i_enable=1 → next cycle outputs match exactly, o_valid=1.
- Load-use on rt:
  - Cycle N: LW loaded (o_mem_read=1, o_rt=5).
  - ID presents R-type with i_rs=2, i_rt=5.
  - Expected: o_stall=1 for exactly one cycle, then a bubble (o_valid=0, o_reg_write=0), then the R-type registers with o_stall=0.
- No false hazard:
  - LW in EX with o_rt=0, ID uses rs=0 → o_stall=0.
  - LW in EX with o_rt=7, ID ADDI with i_rt=7, i_rs=1 → o_stall=0, because rt is the destination and uses_rt=0.
- Flush beats stall: hazard condition present and i_flush=1 → o_stall=0, bubble loaded, o_flush_count +1 (PERF_EN).
- Freeze: i_enable=0 for 3 cycles with changing inputs → outputs unchanged, counters unchanged. Re-enable → normal capture on the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with load-use hazard stall, branch/jump flush and debug freeze.
// Latency : 1 cycle from ID inputs to EX outputs; o_stall is combinational from ID inputs and EX state.
// Backpres: i_enable=0 freezes all state (o_stall forced low); a load-use hazard asserts o_stall and loads a bubble.
//
// Ports:
//   i_clk, i_reset (sync, active-high), i_enable (debug advance), i_flush (squash ID instruction)
//   i_<decoder control fields>, i_rs_data/i_rt_data/i_imm/i_pc4, i_rs/i_rt/i_rd  -> ID instruction
//   o_<same fields>  registered EX copies; o_valid = real instruction in EX, 0 = bubble
//   o_stall          freeze PC and IF/ID this cycle
//   o_stall_count, o_flush_count  perf counters, present only when ID_EX_PERF_EN is defined (else tied 0)
module id_ex_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_reg_write,
    input  logic               i_alu_source,
    input  logic               i_mem_write,
    input  logic               i_mem_read,
    input  logic               i_beq_flag,
    input  logic               i_bne_flag,
    input  logic               i_jump_flag,
    input  logic [2:0]         i_alu_op,
    input  logic [1:0]         i_data_to_reg,
    input  logic [1:0]         i_reg_dst,
    input  logic [1:0]         i_select_addr,
    input  logic [4:0]         i_size_control,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_DATA-1:0] i_pc4,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    output logic               o_reg_write,
    output logic               o_alu_source,
    output logic               o_mem_write,
    output logic               o_mem_read,
    output logic               o_beq_flag,
    output logic               o_bne_flag,
    output logic               o_jump_flag,
    output logic [2:0]         o_alu_op,
    output logic [1:0]         o_data_to_reg,
    output logic [1:0]         o_reg_dst,
    output logic [1:0]         o_select_addr,
    output logic [4:0]         o_size_control,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_DATA-1:0] o_pc4,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic               o_valid,
    output logic               o_stall,
    output logic [NB_CNT-1:0]  o_stall_count,
    output logic [NB_CNT-1:0]  o_flush_count
);

    typedef struct packed {
        logic               reg_write;
        logic               alu_source;
        logic               mem_write;
        logic               mem_read;
        logic               beq_flag;
        logic               bne_flag;
        logic               jump_flag;
        logic [2:0]         alu_op;
        logic [1:0]         data_to_reg;
        logic [1:0]         reg_dst;
        logic [1:0]         select_addr;
        logic [4:0]         size_control;
        logic [NB_DATA-1:0] rs_data;
        logic [NB_DATA-1:0] rt_data;
        logic [NB_DATA-1:0] imm;
        logic [NB_DATA-1:0] pc4;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
        logic               valid;
    } ex_t;

    ex_t  ex_q, ex_d, id_w;
    logic uses_rs, uses_rt, hazard;

    assign id_w = '{reg_write: i_reg_write, alu_source: i_alu_source, mem_write: i_mem_write,
                    mem_read: i_mem_read, beq_flag: i_beq_flag, bne_flag: i_bne_flag,
                    jump_flag: i_jump_flag, alu_op: i_alu_op, data_to_reg: i_data_to_reg,
                    reg_dst: i_reg_dst, select_addr: i_select_addr, size_control: i_size_control,
                    rs_data: i_rs_data, rt_data: i_rt_data, imm: i_imm, pc4: i_pc4,
                    rs: i_rs, rt: i_rt, rd: i_rd, valid: 1'b1};

    // J/JAL (jump with select_addr 00) take their target from the immediate, not rs.
    // rt is a source only for register-operand ALU ops and stores.
    assign uses_rs = !(i_jump_flag && (i_select_addr == 2'b00));
    assign uses_rt = !i_alu_source || i_mem_write;

    // Load in EX whose destination (rt) feeds the ID instruction; $zero never conflicts.
    assign hazard = ex_q.mem_read && ex_q.valid && (ex_q.rt != '0) &&
                    ((uses_rs && (ex_q.rt == i_rs)) || (uses_rt && (ex_q.rt == i_rt)));

    // A flushed ID instruction is discarded, so there is nothing to hold upstream.
    assign o_stall = hazard && i_enable && !i_flush;

    always_comb begin
        ex_d = ex_q;
        if (!i_enable) begin
            ex_d = ex_q;
        end else if (i_flush || hazard) begin
            ex_d = '0;          // bubble: all controls low, valid low
        end else begin
            ex_d = id_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign o_reg_write    = ex_q.reg_write;
    assign o_alu_source   = ex_q.alu_source;
    assign o_mem_write    = ex_q.mem_write;
    assign o_mem_read     = ex_q.mem_read;
    assign o_beq_flag     = ex_q.beq_flag;
    assign o_bne_flag     = ex_q.bne_flag;
    assign o_jump_flag    = ex_q.jump_flag;
    assign o_alu_op       = ex_q.alu_op;
    assign o_data_to_reg  = ex_q.data_to_reg;
    assign o_reg_dst      = ex_q.reg_dst;
    assign o_select_addr  = ex_q.select_addr;
    assign o_size_control = ex_q.size_control;
    assign o_rs_data      = ex_q.rs_data;
    assign o_rt_data      = ex_q.rt_data;
    assign o_imm          = ex_q.imm;
    assign o_pc4          = ex_q.pc4;
    assign o_rs           = ex_q.rs;
    assign o_rt           = ex_q.rt;
    assign o_rd           = ex_q.rd;
    assign o_valid        = ex_q.valid;

`ifdef ID_EX_PERF_EN
    logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;
    logic [NB_CNT-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; o_stall already means "enabled edge loading a hazard bubble".
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + NB_CNT'(1);
        end
        if (i_enable && i_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_count = stall_cnt_q;
    assign o_flush_count = flush_cnt_q;
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : self-checking bench for id_ex_stage (directed scenarios plus randomized run against a reference model).
// Latency : expects one-cycle capture; o_stall checked combinationally before each edge.
// Backpres: exercises hazard stalls, flushes and i_enable freezes.
module tb_id_ex_stage;

    typedef struct packed {
        logic        reg_write;
        logic        alu_source;
        logic        mem_write;
        logic        mem_read;
        logic        beq;
        logic        bne;
        logic        jump;
        logic [2:0]  alu_op;
        logic [1:0]  data_to_reg;
        logic [1:0]  reg_dst;
        logic [1:0]  select_addr;
        logic [4:0]  size_control;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst, en, flush;
    instr_t din, dout;

    logic        o_reg_write, o_alu_source, o_mem_write, o_mem_read;
    logic        o_beq_flag, o_bne_flag, o_jump_flag;
    logic [2:0]  o_alu_op;
    logic [1:0]  o_data_to_reg, o_reg_dst, o_select_addr;
    logic [4:0]  o_size_control;
    logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_valid, o_stall;
    logic [31:0] o_stall_count, o_flush_count;

    // Reference model state: what EX should hold, plus expected counters.
    instr_t      exp_q;
    logic        exp_valid;
    logic [31:0] exp_sc, exp_fc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(flush),
        .i_reg_write(din.reg_write), .i_alu_source(din.alu_source), .i_mem_write(din.mem_write),
        .i_mem_read(din.mem_read), .i_beq_flag(din.beq), .i_bne_flag(din.bne), .i_jump_flag(din.jump),
        .i_alu_op(din.alu_op), .i_data_to_reg(din.data_to_reg), .i_reg_dst(din.reg_dst),
        .i_select_addr(din.select_addr), .i_size_control(din.size_control),
        .i_rs_data(din.rs_data), .i_rt_data(din.rt_data), .i_imm(din.imm), .i_pc4(din.pc4),
        .i_rs(din.rs), .i_rt(din.rt), .i_rd(din.rd),
        .o_reg_write(o_reg_write), .o_alu_source(o_alu_source), .o_mem_write(o_mem_write),
        .o_mem_read(o_mem_read), .o_beq_flag(o_beq_flag), .o_bne_flag(o_bne_flag), .o_jump_flag(o_jump_flag),
        .o_alu_op(o_alu_op), .o_data_to_reg(o_data_to_reg), .o_reg_dst(o_reg_dst),
        .o_select_addr(o_select_addr), .o_size_control(o_size_control),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc4(o_pc4),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_valid(o_valid), .o_stall(o_stall),
        .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
    );

    assign dout = {o_reg_write, o_alu_source, o_mem_write, o_mem_read, o_beq_flag, o_bne_flag,
                   o_jump_flag, o_alu_op, o_data_to_reg, o_reg_dst, o_select_addr, o_size_control,
                   o_rs_data, o_rt_data, o_imm, o_pc4, o_rs, o_rt, o_rd};

    // Load-use rule: a valid load in EX whose nonzero rt is read by the ID instruction.
    function automatic bit model_hazard(instr_t ex, logic v, instr_t id);
        bit reads_rs, reads_rt;
        reads_rs = !(id.jump && id.select_addr == 2'b00);
        reads_rt = !id.alu_source || id.mem_write;
        return ex.mem_read && v && ex.rt != 5'd0 &&
               ((reads_rs && ex.rt == id.rs) || (reads_rt && ex.rt == id.rt));
    endfunction

    function automatic bit model_stall();
        return model_hazard(exp_q, exp_valid, din) && en && !flush;
    endfunction

    function automatic instr_t rand_instr();
        logic [191:0] r;
        instr_t t;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t = instr_t'(r[$bits(instr_t)-1:0]);
        t.rs = 5'($urandom_range(0, 3));
        t.rt = 5'($urandom_range(0, 3));
        return t;
    endfunction

    // Advance one clock edge and update the model by the priority rules.
    task automatic tick();
        bit hz;
        hz = model_hazard(exp_q, exp_valid, din);
        @(posedge clk);
        if (rst) begin
            exp_q = '0; exp_valid = 1'b0; exp_sc = '0; exp_fc = '0;
        end else if (!en) begin
            // hold everything
        end else if (flush) begin
            exp_q = '0; exp_valid = 1'b0;
            if (PERF && exp_fc != 32'hFFFF_FFFF) exp_fc = exp_fc + 32'd1;
        end else if (hz) begin
            exp_q = '0; exp_valid = 1'b0;
            if (PERF && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
        end else begin
            exp_q = din; exp_valid = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'($urandom); flush = 1'($urandom); din = rand_instr();
        tick();
        din = rand_instr();
        tick();
        n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_fields: got %h want 0", dout); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        n_vec++; if ({o_stall_count, o_flush_count} !== 64'd0) begin
            n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", o_stall_count, o_flush_count); end
        rst = 1'b0; en = 1'b1; flush = 1'b0;
    endtask

    task automatic test_passthrough();
        instr_t a;
        a = '0; a.reg_write = 1'b1; a.alu_source = 1'b1; a.alu_op = 3'b001; a.imm = 32'h0000_0010;
        a.rs = 5'd3; a.rt = 5'd4; a.rs_data = 32'hCAFE_0001; a.pc4 = 32'h0000_0104;
        din = a;
        tick();
        n_vec++; if (dout !== a) begin n_err++; $display("FAIL passthrough_fields: got %h want %h", dout, a); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL passthrough_valid: got %b want 1", o_valid); end
    endtask

    task automatic test_load_use();
        instr_t lw, rt;
        lw = '0; lw.mem_read = 1'b1; lw.reg_write = 1'b1; lw.alu_source = 1'b1; lw.data_to_reg = 2'd1;
        lw.rs = 5'd1; lw.rt = 5'd5; lw.imm = 32'd4; lw.pc4 = 32'h108;
        din = lw;
        tick();
        n_vec++; if (o_mem_read !== 1'b1 || o_rt !== 5'd5 || o_valid !== 1'b1) begin
            n_err++; $display("FAIL lu_load: got mr=%b rt=%0d v=%b want 1/5/1", o_mem_read, o_rt, o_valid); end
        rt = '0; rt.reg_write = 1'b1; rt.reg_dst = 2'd1; rt.alu_op = 3'b010; rt.rs = 5'd2; rt.rt = 5'd5;
        rt.rd = 5'd6; rt.rs_data = 32'h1111_2222; rt.rt_data = 32'h3333_4444; rt.pc4 = 32'h10C;
        din = rt;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", o_stall); end
        tick();
        n_vec++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_mem_read !== 1'b0) begin
            n_err++; $display("FAIL lu_bubble: got v=%b rw=%b mr=%b want 0/0/0", o_valid, o_reg_write, o_mem_read); end
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %b want 0", o_stall); end
        n_vec++; if (o_stall_count !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++; $display("FAIL lu_stall_count: got %0d want %0d", o_stall_count, PERF ? 1 : 0); end
        tick();
        n_vec++; if (dout !== rt || o_valid !== 1'b1) begin
            n_err++; $display("FAIL lu_capture: got %h/%b want %h/1", dout, o_valid, rt); end
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_no_restall: got %b want 0", o_stall); end
    endtask

    task automatic test_no_false_hazard();
        instr_t lw, id;
        lw = '0; lw.mem_read = 1'b1; lw.alu_source = 1'b1; lw.rs = 5'd1; lw.rt = 5'd0;
        din = lw;
        tick();
        id = '0; id.reg_write = 1'b1; id.rs = 5'd0; id.rt = 5'd0; id.rd = 5'd3;
        din = id;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL nfh_zero_reg: got %b want 0", o_stall); end
        tick();
        n_vec++; if (dout !== id || o_valid !== 1'b1) begin
            n_err++; $display("FAIL nfh_zero_capture: got %h/%b want %h/1", dout, o_valid, id); end
        lw.rt = 5'd7;
        din = lw;
        tick();
        id = '0; id.reg_write = 1'b1; id.alu_source = 1'b1; id.rs = 5'd1; id.rt = 5'd7; id.imm = 32'h20;
        din = id;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL nfh_addi_dest: got %b want 0", o_stall); end
        tick();
        n_vec++; if (dout !== id || o_valid !== 1'b1) begin
            n_err++; $display("FAIL nfh_addi_capture: got %h/%b want %h/1", dout, o_valid, id); end
    endtask

    task automatic test_back_to_back();
        instr_t a, b, c;
        a = '0; a.mem_read = 1'b1; a.alu_source = 1'b1; a.rs = 5'd1; a.rt = 5'd8;
        b = '0; b.mem_read = 1'b1; b.alu_source = 1'b1; b.rs = 5'd8; b.rt = 5'd9; b.imm = 32'h8;
        c = '0; c.reg_write = 1'b1; c.rs = 5'd9; c.rt = 5'd2; c.rd = 5'd10;
        din = a;
        tick();
        din = b;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall1: got %b want 1", o_stall); end
        tick();
        tick();
        n_vec++; if (dout !== b || o_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_load2: got %h/%b want %h/1", dout, o_valid, b); end
        din = c;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall2: got %b want 1", o_stall); end
        tick();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble2: got %b want 0", o_valid); end
        tick();
        n_vec++; if (dout !== c || o_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_capture: got %h/%b want %h/1", dout, o_valid, c); end
    endtask

    task automatic test_flush_beats_stall();
        instr_t lw, id;
        logic [31:0] fc0;
        lw = '0; lw.mem_read = 1'b1; lw.alu_source = 1'b1; lw.rs = 5'd1; lw.rt = 5'd5;
        din = lw;
        tick();
        id = '0; id.reg_write = 1'b1; id.rs = 5'd5; id.rt = 5'd6; id.rd = 5'd7;
        din = id; flush = 1'b1;
        fc0 = o_flush_count;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", o_stall); end
        tick();
        flush = 1'b0;
        n_vec++; if (dout !== '0 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_bubble: got %h/%b want 0/0", dout, o_valid); end
        n_vec++; if (o_flush_count !== (PERF ? fc0 + 32'd1 : 32'd0)) begin
            n_err++; $display("FAIL flush_count: got %0d want %0d", o_flush_count, PERF ? fc0 + 1 : 0); end
    endtask

    task automatic test_freeze();
        instr_t k, h, nh;
        logic [31:0] sc0, fc0;
        k = rand_instr(); k.mem_read = 1'b1; k.rt = 5'd4;
        din = k;
        tick();
        sc0 = exp_sc; fc0 = exp_fc;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = rand_instr(); din.rs = 5'd4; flush = 1'($urandom);
            #1;
            n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL freeze_stall[%0d]: got %b want 0", i, o_stall); end
            tick();
            n_vec++; if (dout !== k || o_valid !== 1'b1) begin
                n_err++; $display("FAIL freeze_hold[%0d]: got %h/%b want %h/1", i, dout, o_valid, k); end
            n_vec++; if (o_stall_count !== (PERF ? sc0 : 32'd0) || o_flush_count !== (PERF ? fc0 : 32'd0)) begin
                n_err++; $display("FAIL freeze_counters[%0d]: got %0d/%0d want %0d/%0d", i, o_stall_count,
                                  o_flush_count, PERF ? sc0 : 0, PERF ? fc0 : 0); end
        end
        h = '0; h.reg_write = 1'b1; h.rs = 5'd4; h.rt = 5'd1;
        din = h; flush = 1'b0; en = 1'b1;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL freeze_restall: got %b want 1", o_stall); end
        tick();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL freeze_bubble: got %b want 0", o_valid); end
        nh = rand_instr();
        din = nh;
        tick();
        n_vec++; if (dout !== nh || o_valid !== 1'b1) begin
            n_err++; $display("FAIL freeze_resume: got %h/%b want %h/1", dout, o_valid, nh); end
    endtask

    task automatic test_reset_mid_stall();
        instr_t lw, id;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        lw = '0; lw.mem_read = 1'b1; lw.alu_source = 1'b1; lw.rt = 5'd6;
        din = lw;
        tick();
        id = '0; id.reg_write = 1'b1; id.rs = 5'd6; id.rt = 5'd2;
        din = id;
        #1;
        n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rms_stall: got %b want 1", o_stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
            n_err++; $display("FAIL rms_after: got v=%b st=%b want 0/0", o_valid, o_stall); end
    endtask

    task automatic test_random();
        bit want_stall;
        for (int c = 0; c < 3000; c++) begin
            din   = rand_instr();
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            #1;
            want_stall = model_stall();
            n_vec++; if (o_stall !== want_stall) begin
                n_err++; $display("FAIL rand_stall cyc %0d: got %b want %b", c, o_stall, want_stall); end
            tick();
            n_vec++; if (dout !== exp_q || o_valid !== exp_valid) begin
                n_err++; $display("FAIL rand_ex cyc %0d: got %h/%b want %h/%b", c, dout, o_valid, exp_q, exp_valid); end
            n_vec++; if (o_stall_count !== exp_sc || o_flush_count !== exp_fc) begin
                n_err++; $display("FAIL rand_counters cyc %0d: got %0d/%0d want %0d/%0d", c,
                                  o_stall_count, o_flush_count, exp_sc, exp_fc); end
        end
        rst = 1'b0; en = 1'b1; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; din = '0;
        exp_q = '0; exp_valid = 1'b0; exp_sc = '0; exp_fc = '0;
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_load_use();
        test_no_false_hazard();
        test_back_to_back();
        test_flush_beats_stall();
        test_freeze();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
